// File: rtl/riscv_cpu_pkg.sv
// Shared CPU definitions used by the fetch stage: widths, the fetch entry
// record, and the PC alignment helper.
package riscv_cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_MISALIGN_MASK = 32'h0000_0003;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return (pc & PC_MISALIGN_MASK) != 32'h0000_0000;
  endfunction

endpackage

// File: rtl/fetch_order_fifo.sv
// Ordered fetch buffer: slots are allocated at request time (PC stored),
// filled in order as responses return, and read out in order by decode.
module fetch_order_fifo
  import riscv_cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            alloc_en,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_en,
  input  logic [ILEN-1:0] fill_instr,
  input  logic            rd_en,
  output logic [PW-1:0]   used_cnt,
  output logic [PW-1:0]   pend_cnt,
  output logic            filled,
  output fetch_entry_t    head
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  logic [PW-1:0] alloc_ptr_r;
  logic [PW-1:0] fill_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  fetch_entry_t  slot_r [DEPTH];

  // Pointer registers; each advances independently, all clear on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_r <= PTR_ZERO;
      fill_ptr_r  <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
    end else if (clr) begin
      alloc_ptr_r <= PTR_ZERO;
      fill_ptr_r  <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
    end else begin
      if (alloc_en) alloc_ptr_r <= alloc_ptr_r + PTR_ONE;
      if (fill_en)  fill_ptr_r  <= fill_ptr_r + PTR_ONE;
      if (rd_en)    rd_ptr_r    <= rd_ptr_r + PTR_ONE;
    end
  end

  // Slot storage: PC written at allocation, instruction written at fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_r[i] <= '0;
      end
    end else begin
      if (alloc_en && !clr) slot_r[alloc_ptr_r[PW-2:0]].pc    <= alloc_pc;
      if (fill_en && !clr)  slot_r[fill_ptr_r[PW-2:0]].instr  <= fill_instr;
    end
  end

  assign used_cnt = alloc_ptr_r - rd_ptr_r;
  assign pend_cnt = alloc_ptr_r - fill_ptr_r;
  assign filled   = (fill_ptr_r != rd_ptr_r);
  assign head     = slot_r[rd_ptr_r[PW-2:0]];

endmodule

// File: rtl/instr_fetch_chk.sv
// Protocol checker for the instruction-memory channel: a response must always
// correspond to an earlier accepted request.
module instr_fetch_chk (
  input logic clk,
  input logic rst_n,
  input logic req_valid,
  input logic req_ready,
  input logic rsp_valid
);

  logic [7:0] out_cnt_r;
  logic       hs_s;
  logic       rsp_ok_s;

  assign hs_s     = req_valid && req_ready;
  assign rsp_ok_s = rsp_valid && (out_cnt_r != 8'd0);

  // Requests accepted by memory but not yet answered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_r <= 8'd0;
    end else if (hs_s && !rsp_ok_s) begin
      out_cnt_r <= out_cnt_r + 8'd1;
    end else if (!hs_s && rsp_ok_s) begin
      out_cnt_r <= out_cnt_r - 8'd1;
    end else begin
      out_cnt_r <= out_cnt_r;
    end
  end

  // Unsolicited response.
  always @(posedge clk) begin
    if (rst_n && rsp_valid) begin
      assert (out_cnt_r != 8'd0);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues in-order memory reads for pc_in, buffers the
// returned words, and hands them to decode; drops stale responses after a redirect.
module instr_fetch #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  output logic            freeze_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic            dec_misaligned
);

  import riscv_cpu_pkg::*;

  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] CNT_ZERO = PW'(0);
  localparam logic [PW-1:0] CNT_ONE  = PW'(1);
  localparam logic [PW:0]   CREDIT_MAX = (PW + 1)'(DEPTH);

  logic [PW-1:0] used_s;
  logic [PW-1:0] pend_s;
  logic [PW-1:0] discard_cnt_r;
  logic [PW-1:0] discard_nxt_s;
  logic [PW:0]   credit_s;
  logic          filled_s;
  logic          req_hs_s;
  logic          rsp_take_s;
  logic          rsp_drop_s;
  logic          rsp_fill_s;
  logic          dec_hs_s;
  fetch_entry_t  head_s;

  // Credit covers both live slots and responses still owed for flushed requests.
  assign credit_s       = {1'b0, used_s} + {1'b0, discard_cnt_r};
  assign imem_req_valid = rst_n && !halt && !flush && (credit_s < CREDIT_MAX);
  assign req_hs_s       = imem_req_valid && imem_req_ready;
  assign freeze_pc      = !req_hs_s;
  assign imem_addr      = pc_in;

  // A response with nothing outstanding is taken by neither path.
  assign rsp_take_s = imem_rsp_valid && ((discard_cnt_r != CNT_ZERO) || (pend_s != CNT_ZERO));
  assign rsp_drop_s = imem_rsp_valid && (discard_cnt_r != CNT_ZERO);
  assign rsp_fill_s = rsp_take_s && !rsp_drop_s && !flush;
  assign dec_hs_s   = filled_s && dec_ready && !flush;

  // Next discard count: a redirect inherits every unfilled request.
  always_comb begin
    discard_nxt_s = discard_cnt_r;
    if (flush) begin
      discard_nxt_s = discard_cnt_r + pend_s - (rsp_take_s ? CNT_ONE : CNT_ZERO);
    end else if (rsp_drop_s) begin
      discard_nxt_s = discard_cnt_r - CNT_ONE;
    end else begin
      discard_nxt_s = discard_cnt_r;
    end
  end

  // Discard counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_cnt_r <= CNT_ZERO;
    end else begin
      discard_cnt_r <= discard_nxt_s;
    end
  end

  fetch_order_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (flush),
    .alloc_en   (req_hs_s),
    .alloc_pc   (pc_in),
    .fill_en    (rsp_fill_s),
    .fill_instr (imem_rsp_data),
    .rd_en      (dec_hs_s),
    .used_cnt   (used_s),
    .pend_cnt   (pend_s),
    .filled     (filled_s),
    .head       (head_s)
  );

  assign dec_valid      = filled_s;
  assign dec_instr      = head_s.instr;
  assign dec_pc         = head_s.pc;
  assign dec_misaligned = pc_misaligned(head_s.pc);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (DEPTH=2, XLEN=32); instruction words are
// 0xAA000000 + PC so expected values are known by hand.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        flush;
  logic [31:0] pc_in;
  logic        freeze_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_misaligned;

  int errors = 0;
  int checks = 0;

  instr_fetch #(.DEPTH(2), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt           (halt),
    .flush          (flush),
    .pc_in          (pc_in),
    .freeze_pc      (freeze_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_misaligned (dec_misaligned)
  );

  instr_fetch_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (imem_req_valid),
    .req_ready (imem_req_ready),
    .rsp_valid (imem_rsp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic rdy, input logic rv,
                       input logic [31:0] rd, input logic drdy, input logic fl);
    pc_in          = pc;
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    dec_ready      = drdy;
    flush          = fl;
    #1;
  endtask

  task automatic req(input string tag, input logic v, input logic f);
    check({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, v});
    check({tag, ".freeze_pc"}, {31'd0, freeze_pc}, {31'd0, f});
  endtask

  task automatic decv(input string tag, input logic v);
    check({tag, ".dec_valid"}, {31'd0, dec_valid}, {31'd0, v});
  endtask

  task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic mis);
    check({tag, ".dec_pc"}, dec_pc, pc);
    check({tag, ".dec_instr"}, dec_instr, ins);
    check({tag, ".dec_misaligned"}, {31'd0, dec_misaligned}, {31'd0, mis});
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0; halt = 1'b0; flush = 1'b0; pc_in = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; dec_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req(tag, 1'b0, 1'b1);
    decv(tag, 1'b0);
    head(tag, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Latency-1 memory, decode always ready, PC from 0x0.
    apply_reset("rst");
    drive(32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);        req("a0", 1'b1, 1'b0); decv("a0", 1'b0);
    step(); drive(32'h4, 1'b1, 1'b1, 32'hAA00_0000, 1'b1, 1'b0); req("a1", 1'b1, 1'b0); decv("a1", 1'b0);
    step(); drive(32'h8, 1'b1, 1'b1, 32'hAA00_0004, 1'b1, 1'b0); req("a2", 1'b0, 1'b1); decv("a2", 1'b1);
    head("a2", 32'h0, 32'hAA00_0000, 1'b0);
    step(); drive(32'h8, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); req("a3", 1'b1, 1'b0); decv("a3", 1'b1);
    head("a3", 32'h4, 32'hAA00_0004, 1'b0);
    step(); drive(32'hC, 1'b1, 1'b1, 32'hAA00_0008, 1'b1, 1'b0); req("a4", 1'b1, 1'b0); decv("a4", 1'b0);
    step(); drive(32'h10, 1'b0, 1'b1, 32'hAA00_000C, 1'b1, 1'b0); req("a5", 1'b0, 1'b1); decv("a5", 1'b1);
    head("a5", 32'h8, 32'hAA00_0008, 1'b0);
    step(); drive(32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); req("a6", 1'b1, 1'b1); decv("a6", 1'b1);
    head("a6", 32'hC, 32'hAA00_000C, 1'b0);

    // Decode stalled: buffer fills after two requests, PC holds at 0x8.
    step(); apply_reset("rst2");
    drive(32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);        req("b0", 1'b1, 1'b0);
    step(); drive(32'h4, 1'b1, 1'b1, 32'hAA00_0000, 1'b0, 1'b0); req("b1", 1'b1, 1'b0);
    step(); drive(32'h8, 1'b1, 1'b1, 32'hAA00_0004, 1'b0, 1'b0); req("b2", 1'b0, 1'b1);
    step(); drive(32'h8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); req("b3", 1'b0, 1'b1); decv("b3", 1'b1);
    step(); drive(32'h8, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); req("b4", 1'b0, 1'b1);
    head("b4", 32'h0, 32'hAA00_0000, 1'b0);
    step(); drive(32'h8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); req("b5", 1'b1, 1'b0);
    head("b5", 32'h4, 32'hAA00_0004, 1'b0);

    // Flush with 0x10 and 0x14 in flight: both late responses dropped.
    step(); apply_reset("rst3");
    drive(32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);       req("c0", 1'b1, 1'b0);
    step(); drive(32'h14, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); req("c1", 1'b1, 1'b0);
    step(); drive(32'h14, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); req("c2", 1'b0, 1'b1);
    step(); drive(32'h100, 1'b1, 1'b1, 32'hAA00_0010, 1'b1, 1'b0); req("c3", 1'b0, 1'b1); decv("c3", 1'b0);
    step(); drive(32'h100, 1'b1, 1'b1, 32'hAA00_0014, 1'b1, 1'b0); req("c4", 1'b1, 1'b0); decv("c4", 1'b0);
    step(); drive(32'h104, 1'b0, 1'b1, 32'hAA00_0100, 1'b1, 1'b0); req("c5", 1'b1, 1'b1); decv("c5", 1'b0);
    step(); drive(32'h104, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); decv("c6", 1'b1);
    head("c6", 32'h100, 32'hAA00_0100, 1'b0);

    // Flush coincides with the 0x10 response: only 0x14 remains owed.
    step(); apply_reset("rst4");
    drive(32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);       req("d0", 1'b1, 1'b0);
    step(); drive(32'h14, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); req("d1", 1'b1, 1'b0);
    step(); drive(32'h14, 1'b1, 1'b1, 32'hAA00_0010, 1'b1, 1'b1); req("d2", 1'b0, 1'b1); decv("d2", 1'b0);
    step(); drive(32'h200, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); req("d3", 1'b1, 1'b0); decv("d3", 1'b0);
    step(); drive(32'h204, 1'b0, 1'b1, 32'hAA00_0014, 1'b1, 1'b0); req("d4", 1'b0, 1'b1); decv("d4", 1'b0);
    step(); drive(32'h204, 1'b1, 1'b1, 32'hAA00_0200, 1'b1, 1'b0); req("d5", 1'b1, 1'b0); decv("d5", 1'b0);
    step(); drive(32'h208, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); decv("d6", 1'b1);
    head("d6", 32'h200, 32'hAA00_0200, 1'b0);

    // Memory not ready for 5 cycles: request and address held, one handshake.
    step(); apply_reset("rst5");
    for (int i = 0; i < 5; i++) begin
      drive(32'h20, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      req("e_wait", 1'b1, 1'b1);
      check("e_wait.imem_addr", imem_addr, 32'h20);
      step();
    end
    drive(32'h20, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);       req("e5", 1'b1, 1'b0);
    step(); drive(32'h24, 1'b0, 1'b1, 32'hAA00_0020, 1'b1, 1'b0); req("e6", 1'b1, 1'b1);
    step(); drive(32'h24, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); decv("e7", 1'b1);
    head("e7", 32'h20, 32'hAA00_0020, 1'b0);
    step(); drive(32'h24, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); decv("e8", 1'b0);

    // Misaligned PC is delivered flagged; halt blocks new requests.
    step(); apply_reset("rst6");
    drive(32'h22, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);       req("f0", 1'b1, 1'b0);
    step(); drive(32'h26, 1'b0, 1'b1, 32'hAA00_0022, 1'b1, 1'b0);
    step(); halt = 1'b1;
    drive(32'h26, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);       req("f2", 1'b0, 1'b1); decv("f2", 1'b1);
    head("f2", 32'h22, 32'hAA00_0022, 1'b1);
    step(); halt = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
